multicycle_ctrl: RTL

Multicycle control unit driving the RV32 datapath's control inputs (PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC) and the data-memory strobes. It latches the fetched instruction, sequences it through fetch/decode/execute/memory/write-back states, and consumes the datapath's Zero flag to resolve BEQ. Together with the datapath and the instruction/data memories it forms the complete processor.

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: latches the fetched instruction and steps it through
// IF/ID/EX/MEM/WB, driving the datapath controls and the data-memory strobes.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal,
    output logic        halted
);

    localparam int unsigned ALU_W = 4;
    localparam int unsigned OP_W  = 7;

    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_R       = 3'd1,
        CL_I       = 3'd2,
        CL_LW      = 3'd3,
        CL_SW      = 3'd4,
        CL_BEQ     = 3'd5
    } iclass_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       ir;
    iclass_t           iclass;
    logic [ALU_W-1:0]  alu_op;
    logic              imm_op;
    logic [2:0]        funct3;
    logic              alt;
    logic              in_window;
    logic              unused_ir;

    assign funct3    = ir[14:12];
    assign alt       = ir[30];
    // Register fields are consumed by the datapath, not by control.
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    // funct3 to ALU operation; sub_en/sra_en select the IR[30] alternates.
    function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                    input logic       sub_en,
                                                    input logic       sra_en);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Instruction register, loaded only in IF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == ST_IF) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IF;
        end else begin
            state <= state_next;
        end
    end

    // Instruction class and ALU control decode from IR.
    always_comb begin
        iclass = CL_ILLEGAL;
        alu_op = ALU_ADD;
        imm_op = 1'b0;
        case (ir[OP_W-1:0])
            OP_R: begin
                iclass = CL_R;
                alu_op = alu_decode(funct3, alt, alt);
            end
            OP_I: begin
                iclass = CL_I;
                alu_op = alu_decode(funct3, 1'b0, alt);
                imm_op = 1'b1;
            end
            OP_LW: begin
                iclass = CL_LW;
                imm_op = 1'b1;
            end
            OP_SW: begin
                iclass = CL_SW;
                imm_op = 1'b1;
            end
            OP_BEQ: begin
                iclass = CL_BEQ;
                alu_op = ALU_SUB;
            end
            default: begin
                iclass = CL_ILLEGAL;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IF: state_next = ST_ID;
            ST_ID: begin
                if (iclass == CL_ILLEGAL) begin
                    state_next = HALT_ON_ILLEGAL ? ST_HALT : ST_IF;
                end else begin
                    state_next = ST_EX;
                end
            end
            ST_EX: begin
                case (iclass)
                    CL_BEQ:        state_next = ST_IF;
                    CL_LW, CL_SW:  state_next = ST_MEM;
                    default:       state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (iclass == CL_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB:   state_next = ST_IF;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IF;
        endcase
    end

    // ALU fields are held from EX through the last state of the instruction.
    assign in_window = (state == ST_EX) || (state == ST_MEM) || (state == ST_WB);

    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = '0;
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        if (in_window) begin
            ALUCtrl  = alu_op;
            ALUSrc   = imm_op;
            MemToReg = (iclass == CL_LW);
        end
        case (state)
            ST_ID: begin
                if (iclass == CL_ILLEGAL) begin
                    illegal = 1'b1;
                    loadPC  = ~HALT_ON_ILLEGAL;
                end
            end
            ST_EX: begin
                if (iclass == CL_BEQ) begin
                    loadPC = 1'b1;
                    PCSrc  = Zero;
                end
            end
            ST_MEM: begin
                MemRead  = (iclass == CL_LW);
                MemWrite = (iclass == CL_SW);
                loadPC   = (iclass == CL_SW) && mem_ready;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                loadPC   = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
